// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants, state encoding and address helpers for the cache block-fill engine.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (critical-word-first fill order).
package cache_fill_fsm_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned OFFSET_W        = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W           = OFFSET_W + 1;
    localparam int unsigned BLOCK_BYTE_W    = OFFSET_W + 1;
    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    // Clear the byte-within-block bits so the address points at the block base.
    function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] mask;
        mask = ~ADDR_W'((1 << BLOCK_BYTE_W) - 1);
        return addr & mask;
    endfunction

    // Byte offset of a 16-bit word slot inside the block.
    function automatic logic [ADDR_W-1:0] word_byte_offset(input logic [OFFSET_W-1:0] word);
        return ADDR_W'({word, 1'b0});
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache/memory side signals of the fill engine; master = fill engine, slave = cache + memory.
interface cache_fill_fsm_if;
    import cache_fill_fsm_pkg::*;

    logic                miss_detected;
    logic [ADDR_W-1:0]   miss_address;
    logic                mem_grant;
    logic                memory_data_valid;
    logic [DATA_W-1:0]   memory_data;
    logic                fsm_busy;
    logic                mem_req;
    logic [ADDR_W-1:0]   memory_address;
    logic                write_data_array;
    logic [OFFSET_W-1:0] write_word_idx;
    logic                write_tag_array;
    logic [ADDR_W-1:0]   fill_address;

    modport master (
        input  miss_detected, miss_address, mem_grant, memory_data_valid, memory_data,
        output fsm_busy, mem_req, memory_address, write_data_array, write_word_idx,
               write_tag_array, fill_address
    );

    modport slave (
        output miss_detected, miss_address, mem_grant, memory_data_valid, memory_data,
        input  fsm_busy, mem_req, memory_address, write_data_array, write_word_idx,
               write_tag_array, fill_address
    );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for one side of a fill (requests or responses); clear wins over increment.
module fill_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_q
);

    logic [WIDTH-1:0] cnt_d;

    // Next count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one block as pipelined word reads, writes each returned
// word into the data array and installs the tag with the last word.
// Optional feature macro: CRITICAL_WORD_FIRST_EN -- fill starts at the missing word and wraps.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cache_fill_fsm_if.master  bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fill_address_q, fill_address_d;
    logic [CNT_W-1:0]    req_cnt_q, rsp_cnt_q;
    logic                cnt_clr;
    logic                req_inc;
    logic                req_pending;
    logic                rsp_accept;
    logic                rsp_last;
    logic [OFFSET_W-1:0] req_word, rsp_word;
    logic                unused_data;

`ifdef CRITICAL_WORD_FIRST_EN
    logic [OFFSET_W-1:0] crit_q, crit_d;
`endif

    // Returned data goes straight to the data array; the engine never inspects it.
    assign unused_data = ^bus.memory_data;

    // Map a request/response ordinal onto a word slot in the block.
`ifdef CRITICAL_WORD_FIRST_EN
    assign req_word = OFFSET_W'(crit_q + req_cnt_q[OFFSET_W-1:0]);
    assign rsp_word = OFFSET_W'(crit_q + rsp_cnt_q[OFFSET_W-1:0]);
`else
    assign req_word = req_cnt_q[OFFSET_W-1:0];
    assign rsp_word = rsp_cnt_q[OFFSET_W-1:0];
`endif

    // Progress qualifiers; counters saturate the block so extra responses are dropped.
    always_comb begin
        req_pending = (state_q == FILL) && (req_cnt_q < CNT_W'(WORDS_PER_BLOCK));
        rsp_accept  = (state_q == FILL) && bus.memory_data_valid
                      && (rsp_cnt_q < CNT_W'(WORDS_PER_BLOCK));
        rsp_last    = rsp_accept && (rsp_cnt_q == CNT_W'(WORDS_PER_BLOCK - 1));
    end

    // Next-state logic: latch the block base on a miss, return to IDLE on the last word.
    always_comb begin
        state_d        = state_q;
        fill_address_d = fill_address_q;
        cnt_clr        = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
        crit_d         = crit_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    state_d        = FILL;
                    fill_address_d = block_align(bus.miss_address);
                    cnt_clr        = 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
                    crit_d         = bus.miss_address[OFFSET_W:1];
`endif
                end
            end
            FILL: begin
                if (rsp_last) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and block base registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            fill_address_q <= '0;
        end else begin
            state_q        <= state_d;
            fill_address_q <= fill_address_d;
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    // Critical word offset of the current fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_q <= '0;
        end else begin
            crit_q <= crit_d;
        end
    end
`endif

    assign req_inc = req_pending && bus.mem_grant;

    fill_counter #(.WIDTH(CNT_W)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (req_inc),
        .cnt_q (req_cnt_q)
    );

    fill_counter #(.WIDTH(CNT_W)) u_rsp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rsp_accept),
        .cnt_q (rsp_cnt_q)
    );

    // Outputs: busy covers the miss cycle itself so the stall has no bubble.
    assign bus.fsm_busy         = (state_q == FILL) || bus.miss_detected;
    assign bus.mem_req          = req_pending;
    assign bus.memory_address   = req_pending ? (fill_address_q + word_byte_offset(req_word)) : '0;
    assign bus.write_data_array = rsp_accept;
    assign bus.write_word_idx   = rsp_accept ? rsp_word : '0;
    assign bus.write_tag_array  = rsp_last;
    assign bus.fill_address     = fill_address_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: reset/idle vector table, directed fill
// sequences and randomized fills against a queue-based reference model.
module tb_cache_fill_fsm;
    import cache_fill_fsm_pkg::*;

    localparam int MEM_LATENCY = 4;
    localparam int NWI         = int'(WORDS_PER_BLOCK);
    localparam int MAX_CYC     = 80;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk;
    logic rst_n;

    cache_fill_fsm_if bus ();

    cache_fill_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Memory model: due cycles of accepted requests, returned in order.
    int pend_q[$];

    // Reference model: remaining request addresses and write slots of the current fill.
    logic [15:0] exp_addr_q[$];
    int          exp_idx_q[$];
    bit          m_fill = 1'b0;
    logic [15:0] m_base = '0;

    // Observations from the most recent step.
    bit          obs_busy, obs_req, obs_wr, obs_tag;
    logic [15:0] obs_addr;
    int          obs_idx;

    typedef struct {
        bit          rst;
        bit          miss;
        bit          valid;
        bit          grant;
        logic [15:0] addr;
        bit          e_busy;
        bit          e_req;
        bit          e_wr;
        bit          e_tag;
    } vec_t;

    localparam int NV = 8;
    vec_t vec[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_start(input logic [15:0] a);
        int c;
        c      = CWF ? int'((a / 16'd2) % 16'(NWI)) : 0;
        m_base = a - (a % 16'(2 * NWI));
        exp_addr_q.delete();
        exp_idx_q.delete();
        for (int n = 0; n < NWI; n++) begin
            int w;
            w = (c + n) % NWI;
            exp_addr_q.push_back(m_base + 16'(2 * w));
            exp_idx_q.push_back(w);
        end
        m_fill = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check 1ns later, then advance model and memory.
    task automatic step(input bit rst_i, input bit miss_i, input logic [15:0] addr_i,
                        input bit grant_i, input bit extra_v);
        bit v, e_req, e_wr, e_tag;
        @(negedge clk);
        rst_n                 = rst_i;
        bus.miss_detected     = miss_i;
        bus.miss_address      = addr_i;
        bus.mem_grant         = grant_i;
        v                     = extra_v || (pend_q.size() > 0 && pend_q[0] == cyc);
        bus.memory_data_valid = v;
        bus.memory_data       = 16'($urandom);
        if (!rst_i) begin
            m_fill = 1'b0;
            m_base = '0;
            exp_addr_q.delete();
            exp_idx_q.delete();
        end
        #1;
        e_req = m_fill && exp_addr_q.size() > 0;
        e_wr  = m_fill && v && exp_idx_q.size() > 0;
        e_tag = e_wr && exp_idx_q.size() == 1;
        chk("fsm_busy", 32'(bus.fsm_busy), 32'(m_fill || miss_i));
        chk("mem_req", 32'(bus.mem_req), 32'(e_req));
        if (e_req) chk("memory_address", 32'(bus.memory_address), 32'(exp_addr_q[0]));
        chk("write_data_array", 32'(bus.write_data_array), 32'(e_wr));
        if (e_wr) chk("write_word_idx", 32'(bus.write_word_idx), 32'(exp_idx_q[0]));
        chk("write_tag_array", 32'(bus.write_tag_array), 32'(e_tag));
        chk("fill_address", 32'(bus.fill_address), 32'(m_base));

        obs_busy = bus.fsm_busy;
        obs_req  = bus.mem_req;
        obs_addr = bus.memory_address;
        obs_wr   = bus.write_data_array;
        obs_idx  = int'(bus.write_word_idx);
        obs_tag  = bus.write_tag_array;

        if (pend_q.size() > 0 && pend_q[0] == cyc) void'(pend_q.pop_front());
        if (bus.mem_req && grant_i) pend_q.push_back(cyc + MEM_LATENCY);
        if (rst_i) begin
            if (m_fill) begin
                if (e_req && grant_i) void'(exp_addr_q.pop_front());
                if (e_wr) begin
                    void'(exp_idx_q.pop_front());
                    if (exp_idx_q.size() == 0) m_fill = 1'b0;
                end
            end else if (miss_i) begin
                model_start(addr_i);
            end
        end
        cyc++;
    endtask

    // Miss held until the tag write (or until rst_after writes); gmode 0 = grant always,
    // 1 = grant low on the 3rd/4th request cycles, 2 = random grant.
    task automatic run_fill(input logic [15:0] addr, input int gmode, input int rst_after,
                            output int tag_rel, output int n_wr, output int busy_n,
                            output logic [15:0] first_addr, output int first_idx);
        int rel;
        bit done, first_r;
        rel = 0; done = 1'b0; first_r = 1'b0;
        tag_rel = -1; n_wr = 0; busy_n = 0; first_addr = '0; first_idx = -1;
        while (!done && rel < MAX_CYC) begin
            bit g;
            case (gmode)
                0:       g = 1'b1;
                1:       g = !(rel == 3 || rel == 4);
                default: g = ($urandom_range(0, 3) != 0);
            endcase
            step(1'b1, 1'b1, addr, g, 1'b0);
            if (obs_busy) busy_n++;
            if (obs_req && !first_r) begin
                first_r    = 1'b1;
                first_addr = obs_addr;
            end
            if (obs_wr) begin
                if (n_wr == 0) first_idx = obs_idx;
                n_wr++;
            end
            if (obs_tag) begin
                tag_rel = rel;
                done    = 1'b1;
            end
            if (rst_after > 0 && n_wr == rst_after) done = 1'b1;
            rel++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL fill_timeout: no completion within %0d cycles at 0x%0h", MAX_CYC, addr);
        end
    endtask

    // Idle cycles with miss low; optional stray valid pulses. Returns writes seen.
    task automatic idle(input int n, input bit strays, output int wr_seen);
        wr_seen = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'($urandom_range(0, 1)), strays && ($urandom_range(0, 1) == 1));
            if (obs_wr || obs_tag) wr_seen++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tag_rel, n_wr, busy_n, first_idx, wr_seen;
        logic [15:0] first_addr;
        logic [15:0] raddr;

        rst_n                 = 1'b0;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.mem_grant         = 1'b0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = '0;

        // Reset/IDLE vectors: nothing but busy may react, and only to a miss.
        vec[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h1236, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1236, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n                 = vec[i].rst;
            bus.miss_detected     = vec[i].miss;
            bus.memory_data_valid = vec[i].valid;
            bus.mem_grant         = vec[i].grant;
            bus.miss_address      = vec[i].addr;
            #1;
            chk($sformatf("vec%0d_busy", i), 32'(bus.fsm_busy), 32'(vec[i].e_busy));
            chk($sformatf("vec%0d_req", i), 32'(bus.mem_req), 32'(vec[i].e_req));
            chk($sformatf("vec%0d_wr", i), 32'(bus.write_data_array), 32'(vec[i].e_wr));
            chk($sformatf("vec%0d_tag", i), 32'(bus.write_tag_array), 32'(vec[i].e_tag));
            chk($sformatf("vec%0d_fill_addr", i), 32'(bus.fill_address), 32'h0);
        end
        bus.memory_data_valid = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(2, 1'b0, wr_seen);

        // Basic fill at 0x1236 with grant always high.
        run_fill(16'h1236, 0, 0, tag_rel, n_wr, busy_n, first_addr, first_idx);
        chk("t1_tag_cycle", 32'(tag_rel), 32'd12);
        chk("t1_writes", 32'(n_wr), 32'(NWI));
        chk("t1_busy_cycles", 32'(busy_n), 32'd13);
        chk("t1_first_addr", 32'(first_addr), CWF ? 32'h1236 : 32'h1230);
        idle(4, 1'b0, wr_seen);
        chk("t1_idle_writes", 32'(wr_seen), 32'd0);

        // Grant withheld on two request cycles delays the tag by two.
        run_fill(16'h1236, 1, 0, tag_rel, n_wr, busy_n, first_addr, first_idx);
        chk("t2_tag_cycle", 32'(tag_rel), 32'd14);
        chk("t2_writes", 32'(n_wr), 32'(NWI));
        idle(4, 1'b0, wr_seen);

        // Reset after five writes, stray responses afterwards, then a fresh fill.
        run_fill(16'h4440, 0, 5, tag_rel, n_wr, busy_n, first_addr, first_idx);
        chk("t3_writes_before_rst", 32'(n_wr), 32'd5);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("t3_rst_busy", 32'(obs_busy), 32'd0);
        chk("t3_rst_tag", 32'(obs_tag), 32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        idle(10, 1'b0, wr_seen);
        chk("t3_stray_writes", 32'(wr_seen), 32'd0);
        chk("t3_strays_drained", 32'(pend_q.size()), 32'd0);
        run_fill(16'h2220, 0, 0, tag_rel, n_wr, busy_n, first_addr, first_idx);
        chk("t3_restart_idx", 32'(first_idx), 32'd0);
        chk("t3_restart_writes", 32'(n_wr), 32'(NWI));
        idle(3, 1'b0, wr_seen);

        // Miss held across the fill: back-to-back fill starts right after the tag.
        run_fill(16'h3000, 0, 0, tag_rel, n_wr, busy_n, first_addr, first_idx);
        run_fill(16'h3000, 0, 0, tag_rel, n_wr, busy_n, first_addr, first_idx);
        chk("t4_second_tag_cycle", 32'(tag_rel), 32'd12);
        chk("t4_second_busy", 32'(busy_n), 32'd13);
        idle(12, 1'b1, wr_seen);
        chk("t4_idle_stray_writes", 32'(wr_seen), 32'd0);

        // Critical-word miss address; order depends on the build.
        run_fill(16'h123A, 0, 0, tag_rel, n_wr, busy_n, first_addr, first_idx);
        chk("t5_first_addr", 32'(first_addr), CWF ? 32'h123A : 32'h1230);
        chk("t5_first_idx", 32'(first_idx), CWF ? 32'd5 : 32'd0);
        chk("t5_writes", 32'(n_wr), 32'(NWI));
        idle(3, 1'b0, wr_seen);

        // Randomized fills with random grants and stray responses between fills.
        for (int k = 0; k < 20; k++) begin
            raddr = 16'($urandom);
            run_fill(raddr, 2, 0, tag_rel, n_wr, busy_n, first_addr, first_idx);
            chk("rnd_writes", 32'(n_wr), 32'(NWI));
            idle(2 + int'($urandom_range(0, 3)), 1'b1, wr_seen);
            chk("rnd_idle_writes", 32'(wr_seen), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
